// File: rtl/subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : subtractor_seq
//  Purpose  : Multi-cycle subtractor, diff = in1 - in2 - bin, CHUNK bits per
//             cycle LSB first through a registered borrow, start/busy/done.
//  Revision : 1.0  initial release
// ============================================================================
module subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   w_sub;
  logic [WIDTH-1:0] w_res_shift;

  // Top bit of the (CHUNK+1)-bit difference is the borrow out of this chunk.
  assign w_sub = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
               - {{CHUNK{1'b0}}, borrow_q};

  generate
    if (CHUNK == WIDTH) begin : g_single
      assign w_res_shift = w_sub[CHUNK-1:0];
    end else begin : g_multi
      assign w_res_shift = {w_sub[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          borrow_d = bin;
          sa_d     = in1[WIDTH-1];
          sb_d     = in2[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        borrow_d = w_sub[CHUNK];
        res_d    = w_res_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          diff_d  = w_res_shift;
          bout_d  = w_sub[CHUNK];
          zero_d  = (w_res_shift == '0);
          ovf_d   = (sa_q != sb_q) && (w_res_shift[WIDTH-1] != sa_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subtractor_seq
//  Purpose  : Self-checking bench for subtractor_seq (CHUNK=8 and CHUNK=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_subtractor_seq;

  localparam int W = 32;

  typedef struct packed {
    logic         bout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] diff;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in1, in2;
  logic         bin;

  logic         busy8, done8, bout8, ovf8, zero8;
  logic [W-1:0] diff8;
  logic         busy32, done32, bout32, ovf32, zero32;
  logic [W-1:0] diff32;

  res_t got8, got32, held;
  assign got8  = '{bout: bout8,  ovf: ovf8,  zero: zero8,  diff: diff8};
  assign got32 = '{bout: bout32, ovf: ovf32, zero: zero32, diff: diff32};

  subtractor_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  subtractor_seq #(.WIDTH(W), .CHUNK(32)) dut_full (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .bin(bin),
    .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .ovf(ovf32), .zero(zero32)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Plain-integer reference: wide unsigned for borrow, wide signed for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t                r;
    longint              ua, ub, s;
    logic signed [W-1:0] t;
    ua     = longint'(a);
    ub     = longint'(b);
    r.diff = W'(ua - ub - longint'(bi));
    r.bout = (ua < ub + longint'(bi));
    r.zero = (r.diff == '0);
    s      = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    t      = s[W-1:0];
    r.ovf  = (longint'(t) != s);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic op8(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t e;
    bit   run_ok;
    e      = model(a, b, bi);
    run_ok = 1'b1;
    in1 = a; in2 = b; bin = bi; start = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      if (!(busy8 === 1'b1 && done8 === 1'b0 && got8 === held)) run_ok = 1'b0;
      start = (k == 2 || k == 3);
      in1   = $urandom;
      in2   = $urandom;
      bin   = 1'($urandom);
      step();
    end
    check($sformatf("%s run", tag), 64'(run_ok), 64'd1);
    check($sformatf("%s done", tag), 64'({done8, busy8}), 64'b10);
    check($sformatf("%s result", tag), 64'(got8), 64'(e));
    held = e;
  endtask

  task automatic idle_step(input string tag);
    step();
    check($sformatf("%s idle", tag), 64'({done8, busy8, got8}), 64'({2'b00, held}));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbi;
    res_t         e;

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
    held = '0;
    #3;
    check("reset8", 64'({done8, busy8, got8}), 64'd0);
    check("reset32", 64'({done32, busy32, got32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    op8("5-3", 32'h0000_0005, 32'h0000_0003, 1'b0);
    idle_step("after 5-3");
    op8("0-1", 32'h0000_0000, 32'h0000_0001, 1'b0);
    op8("min-1", 32'h8000_0000, 32'h0000_0001, 1'b0);
    op8("max-neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle_step("after max-neg1");
    op8("zero", 32'h1234_5678, 32'h1234_5677, 1'b1);
    op8("b2b 10-1", 32'h0000_0010, 32'h0000_0001, 1'b0);
    idle_step("after b2b");

    // Asynchronous reset in the middle of cycle 2 of RUN.
    in1 = 32'h0000_0099; in2 = 32'h0000_0011; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst8", 64'({done8, busy8, got8}), 64'd0);
    check("async rst32", 64'(got32), 64'd0);
    held = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    idle_step("post rst");
    idle_step("post rst no done");
    op8("A-3", 32'h0000_000A, 32'h0000_0003, 1'b0);
    idle_step("after A-3");

    for (int i = 0; i < 24; i++) begin
      rbi = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = ra - 32'(rbi); end
        1: begin ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3)); rb = $urandom; end
        2: begin ra = $urandom_range(0, 15); rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      op8($sformatf("rand%0d", i), ra, rb, rbi);
      if ($urandom_range(0, 1) == 1) idle_step($sformatf("rand%0d gap", i));
    end
    idle_step("pre full");
    idle_step("pre full 2");

    // Single-chunk instance: done in cycle 2.
    e = model(32'h0000_0005, 32'h0000_0003, 1'b0);
    in1 = 32'h0000_0005; in2 = 32'h0000_0003; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("full cycle1", 64'({done32, busy32}), 64'b01);
    step();
    check("full cycle2", 64'({done32, busy32}), 64'b10);
    check("full result", 64'(got32), 64'(e));
    step();
    check("full cycle3", 64'({done32, busy32, got32}), 64'({2'b00, e}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
